// File: rtl/ofdm_subcarrier_mapper_if.sv
// Stream interface between the bit source, the subcarrier mapper and the IFFT.
//
// Handshake: a sample moves on every rising clock edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, the
// producer holds sample, out_index and out_last stable. The input side has no
// backpressure: in_bit is taken on every edge where in_valid is high.
//
//   in_bit     coded bit, qualified by in_valid
//   in_valid   input qualifier
//   out_ready  IFFT accepts the current sample
//   out_valid  sample/out_index/out_last are valid
//   sample     2-bit real value: 01=+1, 11=-1, 00=null
//   out_index  IFFT bin 0..63
//   out_last   high with bin 63
//
// Modports: slave is the mapper side; master is the side that feeds bits in
// and consumes samples.
interface ofdm_subcarrier_mapper_if;
    logic       in_bit;
    logic       in_valid;
    logic       out_ready;
    logic       out_valid;
    logic [1:0] sample;
    logic [5:0] out_index;
    logic       out_last;

    modport master (
        output in_bit, in_valid, out_ready,
        input  out_valid, sample, out_index, out_last
    );

    modport slave (
        input  in_bit, in_valid, out_ready,
        output out_valid, sample, out_index, out_last
    );
endinterface

// File: rtl/ofdm_subcarrier_mapper.sv
// OFDM subcarrier mapper: collects 48 coded bits per symbol into one of two
// ping-pong banks, BPSK-maps them onto the 48 data subcarriers, inserts the
// four polarity-modulated pilots, nulls DC and guard bins, and streams 64
// samples per symbol in IFFT bin order.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   frame_start one-cycle pulse on the first bit of a PPDU
//   bus         stream interface (slave modport)
//   overflow    sticky, set when an input bit is dropped
//   state_dbg   output FSM state (0=IDLE, 1=EMIT)
module ofdm_subcarrier_mapper #(
    parameter logic [6:0] POL_INIT = 7'h7F
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame_start,
    ofdm_subcarrier_mapper_if.slave         bus,
    output logic                            overflow,
    output logic                            state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state;
    logic [47:0] bank_a;
    logic [47:0] bank_b;
    logic [1:0]  full;
    logic        wr_bank;
    logic [5:0]  wr_ptr;
    logic        rd_bank;
    logic [6:0]  lfsr;

    logic        wr_fire;
    logic        wr_last;
    logic        cur_ready;
    logic        nxt_ready;
    logic        transfer;
    logic        release_bank;
    logic        pilot_bit;
    logic [47:0] rd_bits;
    logic [5:0]  next_bin;

    // A bit is stored unless the bank under the write pointer is still full,
    // which only happens when both banks hold unsent symbols.
    assign wr_fire      = bus.in_valid && !full[wr_bank];
    assign wr_last      = wr_fire && (wr_ptr == 6'd47);

    // Look ahead at the bit-47 write so bin 0 appears the cycle after it.
    assign cur_ready    = full[rd_bank]  || (wr_last && (wr_bank == rd_bank));
    assign nxt_ready    = full[~rd_bank] || (wr_last && (wr_bank != rd_bank));

    assign transfer     = bus.out_valid && bus.out_ready;
    assign release_bank = (state == EMIT) && transfer && (bus.out_index == 6'd63);
    assign pilot_bit    = lfsr[6] ^ lfsr[3];
    assign rd_bits      = rd_bank ? bank_b : bank_a;
    assign next_bin     = bus.out_index + 6'd1;
    assign state_dbg    = state;

    // Sample value for one bin. Positive-frequency data bins start at d24;
    // negative-frequency data bins start at d0 (the pointer wraps 47->0).
    function automatic logic [1:0] bin_sample(input logic [5:0] bin,
                                              input logic [47:0] bits,
                                              input logic pol);
        logic [5:0] d;
        logic [1:0] res;
        d   = 6'd0;
        res = 2'b00;
        if (bin == 6'd0 || (bin >= 6'd27 && bin <= 6'd37)) begin
            res = 2'b00;
        end else if (bin == 6'd7 || bin == 6'd43 || bin == 6'd57) begin
            res = pol ? 2'b11 : 2'b01;
        end else if (bin == 6'd21) begin
            res = pol ? 2'b01 : 2'b11;
        end else begin
            if (bin <= 6'd26) begin
                d = bin + 6'd23;
                if (bin > 6'd7)  d = d - 6'd1;
                if (bin > 6'd21) d = d - 6'd1;
            end else begin
                d = bin - 6'd38;
                if (bin > 6'd43) d = d - 6'd1;
                if (bin > 6'd57) d = d - 6'd1;
            end
            res = bits[d] ? 2'b01 : 2'b11;
        end
        return res;
    endfunction

    // Write side: bank fill, full flags and overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_a   <= '0;
            bank_b   <= '0;
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            wr_ptr   <= 6'd0;
            overflow <= 1'b0;
        end else if (frame_start) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            overflow <= 1'b0;
            if (bus.in_valid) begin
                bank_a[0] <= bus.in_bit;
                wr_ptr    <= 6'd1;
            end else begin
                wr_ptr    <= 6'd0;
            end
        end else begin
            if (release_bank) begin
                full[rd_bank] <= 1'b0;
            end
            if (bus.in_valid && full[wr_bank]) begin
                overflow <= 1'b1;
            end
            if (wr_fire) begin
                if (wr_bank) bank_b[wr_ptr] <= bus.in_bit;
                else         bank_a[wr_ptr] <= bus.in_bit;
                if (wr_ptr == 6'd47) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_ptr        <= 6'd0;
                end else begin
                    wr_ptr        <= wr_ptr + 6'd1;
                end
            end
        end
    end

    // Output FSM with registered sample/index/last/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            lfsr          <= POL_INIT;
            bus.out_valid <= 1'b0;
            bus.sample    <= 2'b00;
            bus.out_index <= 6'd0;
            bus.out_last  <= 1'b0;
        end else if (frame_start) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            lfsr          <= POL_INIT;
            bus.out_valid <= 1'b0;
            bus.sample    <= 2'b00;
            bus.out_index <= 6'd0;
            bus.out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cur_ready) begin
                        state         <= EMIT;
                        bus.out_valid <= 1'b1;
                        bus.sample    <= 2'b00;
                        bus.out_index <= 6'd0;
                        bus.out_last  <= 1'b0;
                    end
                end
                EMIT: begin
                    if (transfer) begin
                        if (bus.out_index == 6'd63) begin
                            lfsr          <= {lfsr[5:0], pilot_bit};
                            rd_bank       <= ~rd_bank;
                            bus.sample    <= 2'b00;
                            bus.out_index <= 6'd0;
                            bus.out_last  <= 1'b0;
                            if (nxt_ready) begin
                                bus.out_valid <= 1'b1;
                            end else begin
                                bus.out_valid <= 1'b0;
                                state         <= IDLE;
                            end
                        end else begin
                            bus.out_index <= next_bin;
                            bus.sample    <= bin_sample(next_bin, rd_bits, pilot_bit);
                            bus.out_last  <= (next_bin == 6'd63);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_subcarrier_mapper.sv
module tb_ofdm_subcarrier_mapper;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic frame_start = 1'b0;
    logic overflow;
    logic state_dbg;

    ofdm_subcarrier_mapper_if bus ();

    ofdm_subcarrier_mapper #(.POL_INIT(7'h7F)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .bus        (bus.slave),
        .overflow   (overflow),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [1:0] p7_q[$];
    logic [1:0] p21_q[$];
    logic [1:0] obs[64];
    logic [6:0] m_lfsr = 7'h7F;
    logic [8:0] mon_exp;
    logic [8:0] mon_got;

    int         ones_bin[10] = '{0, 1, 6, 7, 21, 27, 37, 43, 57, 63};
    logic [1:0] ones_val[10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    logic [1:0] pil7_val[6]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    logic [1:0] pil21_val[6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b01};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected model: walk the data pointer from 24, wrapping at 47.
    task automatic push_symbol(input logic [47:0] bits);
        int ptr;
        logic o;
        logic [1:0] pos, neg, s;
        logic [5:0] b6;
        ptr = 24;
        o   = m_lfsr[6] ^ m_lfsr[3];
        pos = o ? 2'b11 : 2'b01;
        neg = o ? 2'b01 : 2'b11;
        for (int b = 0; b < 64; b++) begin
            if (b == 0 || (b >= 27 && b <= 37)) s = 2'b00;
            else if (b == 7 || b == 43 || b == 57) s = pos;
            else if (b == 21) s = neg;
            else begin
                s   = bits[ptr] ? 2'b01 : 2'b11;
                ptr = (ptr == 47) ? 0 : ptr + 1;
            end
            b6 = b[5:0];
            exp_q.push_back({(b == 63), b6, s});
        end
        m_lfsr = {m_lfsr[5:0], o};
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        tick();
        bus.in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_symbol(input logic [47:0] bits, input int gap);
        for (int i = 0; i < 48; i++) send_bit(bits[i], gap);
    endtask

    task automatic do_frame_start(input logic with_bit, input logic b);
        frame_start  = 1'b1;
        bus.in_valid = with_bit;
        bus.in_bit   = b;
        tick();
        frame_start  = 1'b0;
        bus.in_valid = 1'b0;
        m_lfsr       = 7'h7F;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_bin(input logic [5:0] bin, input int budget, input string name);
        int n;
        n = 0;
        while (!(bus.out_valid && bus.out_index == bin) && n < budget) begin
            tick();
            n++;
        end
        check(name, (bus.out_valid && bus.out_index == bin), 1);
    endtask

    // Monitor: every accepted sample is compared against the next expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            obs[bus.out_index] = bus.sample;
            if (bus.out_index == 6'd7)  p7_q.push_back(bus.sample);
            if (bus.out_index == 6'd21) p21_q.push_back(bus.sample);
            mon_got = {bus.out_last, bus.out_index, bus.sample};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got %0h, expected no output", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                check($sformatf("out_bin%0d", mon_exp[7:2]), mon_got, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [1:0] held;
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sample",    bus.sample,    0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_out_last",  bus.out_last,  0);
        check("rst_overflow",  overflow,      0);
        check("rst_state",     state_dbg,     0);
        rst_n = 1'b1;
        tick();
        do_frame_start(1'b0, 1'b0);

        // All-ones symbol, with latency check on bit 47
        bus.out_ready = 1'b1;
        push_symbol({48{1'b1}});
        for (int i = 0; i < 47; i++) send_bit(1'b1, 0);
        check("pre_latency_valid", bus.out_valid, 0);
        send_bit(1'b1, 0);
        check("latency_valid", bus.out_valid, 1);
        check("latency_index", bus.out_index, 0);
        wait_drain(200, "ones");
        for (int i = 0; i < 10; i++)
            check($sformatf("ones_bin%0d", ones_bin[i]), obs[ones_bin[i]], ones_val[i]);

        // Alternating bits d_n = n mod 2
        push_symbol(48'hAAAA_AAAA_AAAA);
        send_symbol(48'hAAAA_AAAA_AAAA, 0);
        wait_drain(200, "alt");
        check("alt_bin1",  obs[1],  2'b11);
        check("alt_bin2",  obs[2],  2'b01);
        check("alt_bin38", obs[38], 2'b11);
        check("alt_bin39", obs[39], 2'b01);
        check("alt_bin63", obs[63], 2'b01);

        // Pilot polarity over six all-zero symbols
        do_frame_start(1'b0, 1'b0);
        p7_q.delete();
        p21_q.delete();
        for (int s = 0; s < 6; s++) begin
            push_symbol(48'd0);
            send_symbol(48'd0, 1);
        end
        wait_drain(300, "pilot");
        check("pilot_count", p7_q.size(), 6);
        for (int s = 0; s < 6 && s < p7_q.size() && s < p21_q.size(); s++) begin
            check($sformatf("pilot7_sym%0d", s),  p7_q[s],  pil7_val[s]);
            check($sformatf("pilot21_sym%0d", s), p21_q[s], pil21_val[s]);
        end
        check("pilot_overflow", overflow, 0);

        // Backpressure at bin 30 while input continues at 1 bit per 2 cycles
        do_frame_start(1'b0, 1'b0);
        fork
            begin
                push_symbol(48'h1234_5678_9ABC);
                send_symbol(48'h1234_5678_9ABC, 1);
                push_symbol(48'hC3A5_0FF0_5A3C);
                send_symbol(48'hC3A5_0FF0_5A3C, 1);
            end
            begin
                wait_bin(6'd30, 400, "bp_reach_bin30");
                bus.out_ready = 1'b0;
                held = bus.sample;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    check($sformatf("bp_hold_index_%0d", i), bus.out_index, 30);
                    check($sformatf("bp_hold_sample_%0d", i), bus.sample, held);
                end
                bus.out_ready = 1'b1;
                tick();
                check("bp_next_index", bus.out_index, 31);
            end
        join
        wait_drain(300, "bp");
        check("bp_overflow", overflow, 0);

        // Overflow: 97 bits with the IFFT stalled
        do_frame_start(1'b0, 1'b0);
        bus.out_ready = 1'b0;
        push_symbol(48'hF0F0_0F0F_3C3C);
        push_symbol(48'h0123_4567_89AB);
        send_symbol(48'hF0F0_0F0F_3C3C, 0);
        send_symbol(48'h0123_4567_89AB, 0);
        check("ovf_before_97", overflow, 0);
        send_bit(1'b1, 0);
        check("ovf_after_97", overflow, 1);
        bus.out_ready = 1'b1;
        wait_drain(400, "ovf");
        check("ovf_sticky", overflow, 1);
        do_frame_start(1'b0, 1'b0);
        check("ovf_cleared_by_fs", overflow, 0);

        // FrameStart mid-fill with a bit in the same cycle
        for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
        do_frame_start(1'b1, 1'b1);
        push_symbol({47'd0, 1'b1});
        for (int i = 0; i < 47; i++) send_bit(1'b0, 1);
        wait_drain(200, "fs");
        check("fs_bin38_d0", obs[38], 2'b01);
        check("fs_bin39",    obs[39], 2'b11);
        check("fs_bin7_p0",  obs[7],  2'b01);

        // Advance to symbol 5 (negative pilot), then reset at bin 40
        for (int s = 0; s < 4; s++) begin
            push_symbol(48'd0);
            send_symbol(48'd0, 1);
        end
        wait_drain(300, "adv");
        push_symbol(48'd0);
        send_symbol(48'd0, 0);
        wait_bin(6'd40, 200, "rst_reach_bin40");
        check("sym5_bin7_negative", obs[7], 2'b11);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_sample",    bus.sample,    0);
        check("mid_rst_out_index", bus.out_index, 0);
        check("mid_rst_out_last",  bus.out_last,  0);
        check("mid_rst_overflow",  overflow,      0);
        check("mid_rst_state",     state_dbg,     0);
        exp_q.delete();
        tick();
        rst_n  = 1'b1;
        m_lfsr = 7'h7F;
        tick();
        p7_q.delete();
        push_symbol(48'd0);
        send_symbol(48'd0, 0);
        wait_drain(200, "post_rst");
        check("post_rst_p_count", p7_q.size(), 1);
        check("post_rst_bin7_p0", obs[7], 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_subcarrier_mapper.md
# ofdm_subcarrier_mapper

Downstream stage of the transmitter. It takes the serial coded and interleaved bit stream and BPSK-maps each 48-bit OFDM symbol onto the 48 data subcarriers. It inserts the four polarity-modulated pilots and nulls the DC and guard bins. It then streams 64 frequency-domain samples per symbol, in IFFT bin order, over a valid/ready handshake to the IFFT stage.

## Interface
- POL_INIT, 7'h7F: pilot-polarity LFSR seed, loaded on reset and on FrameStart.
- Clock  in  1  single rising-edge clock for all logic; must supply at least 64 cycles per 48 input bits.
- Reset  in  1  asynchronous, active-low; all state is cleared while low.
- FrameStart  in  1  one-cycle pulse at the start of a PPDU (first SIGNAL bit).
- Input  in  1  coded bit; sampled only when InValid=1.
- InValid  in  1  Input qualifier.
- OutReady  in  1  IFFT accepts the current sample.
- OutValid  out  1  Sample, OutIndex and OutLast are valid.
- Sample  out  2  two's-complement real value: 01=+1, 11=−1, 00=null. Imaginary part is implicitly 0.
- OutIndex  out  6  IFFT bin 0..63.
- OutLast  out  1  high with bin 63.
- Overflow  out  1  sticky; set when an input bit is dropped.

## Operation
- Input side, two 48-bit banks (A and B):
  - The write pointer fills the current bank, bit n at position n.
  - On the 48th bit the bank is marked full and the write side switches to the other bank.
- If InValid=1 while both banks are full:
  - The bit is dropped and Overflow is set.
  - Overflow clears only on Reset or FrameStart.
- Output FSM states:
  - IDLE: wait for a full bank.
  - EMIT: bin counter i=0..63, advancing on each OutValid && OutReady.
  - On the bin-63 transfer: release the bank and advance the pilot LFSR. Go to EMIT if the other bank is full, else IDLE.
- Bin to subcarrier: bins 1..26 are k=1..26; bins 38..63 are k=−26..−1.
- Null bins: 0 (DC) and 27..37 (guard) output 00.
- Data bit pointer:
  - Starts at 24 at bin 1.
  - Increments on every data bin and wraps 47→0, so bin 38 (k=−26) is d0.
  - Bins 1..6, 8..20, 22..26 carry d24..d29, d30..d42, d43..d47.
  - Bins 38..42, 44..56, 58..63 carry d0..d4, d5..d17, d18..d23.
- BPSK mapping: bit 1 → +1, bit 0 → −1.
- Pilots:
  - Bin 7 (k=7), bin 43 (k=−21) and bin 57 (k=−7) carry +p.
  - Bin 21 (k=21) carries −p.
  - p=+1 when the LFSR output is 0, and −1 when it is 1.
- Pilot LFSR:
  - Polynomial x^7+x^4+1; output o = s[6]^s[3].
  - On advance, shift left and insert o.
  - Symbol 0 of each frame uses the seed's first output.
  - The sequence repeats every 127 symbols with no special handling.
- FrameStart, in the cycle it is high:
  - Clear both banks and the write pointer.
  - Reload the LFSR with POL_INIT, clear Overflow, and abort any emission (FSM to IDLE).
  - An InValid bit in the same cycle is stored as d0 of the new frame.

## Timing
- Reset values:
  - OutValid=0, Sample=00, OutIndex=0, OutLast=0, Overflow=0.
  - LFSR=POL_INIT, FSM=IDLE, both banks empty.
- Latency: OutValid rises the cycle after the edge that writes bit 47, with OutIndex=0.
- Output registers hold Sample, OutIndex and OutLast stable while OutValid=1 and OutReady=0.
- Back-to-back symbols: when the other bank is full at the bin-63 transfer, bin 0 of the next symbol is presented the following cycle with no bubble.
- A released bank is writable in the cycle after the bin-63 transfer. A simultaneous write and release of different banks is legal.
- Reset assertion mid-symbol clears everything immediately. The first symbol after release uses p0.

## Test plan
- **All-ones symbol**: Reset, FrameStart, 48 bits of 1, OutReady=1. Required output:
  - Bin 0=00, bins 1..6=01, bin 7=01 (p0=+1), bin 21=11, bins 27..37=00.
  - Bin 43=01, bin 57=01, OutLast only at bin 63.
  - First OutValid one cycle after bit 47.
- **Alternating bits d_n=n mod 2**: bin 1 (d24)=11, bin 2=01, bin 38 (d0)=11, bin 39 (d1)=01, bin 63 (d23)=01.
- **Pilot polarity**: six consecutive all-zero symbols. Bin 7 reads 01, 01, 01, 01, 11, 11 for symbols 0..5, and bin 21 is the negation of bin 7 in each symbol.
- **Backpressure**: OutReady held low for 10 cycles at bin 30. OutIndex stays 30, Sample is stable, and the next transfer is bin 31. No bits are lost while input continues at 1 bit per 2 cycles.
- **Overflow**: OutReady=0 while 97 bits are driven. Overflow=1 after bit 97, and the first 96 bits are emitted intact once OutReady=1.
- **FrameStart and reset mid-operation**:
  - 20 bits, then FrameStart with InValid=1 and Input=1, then 47 more bits: the first emitted symbol has d0=1 (bin 38=01) and uses p0.
  - Reset pulled low at bin 40: all outputs read their reset values within the same cycle.
